// File: rtl/eth_pkg.sv
// eth_pkg: shared FSM states, protocol constants and CRC helper for the Ethernet/UDP datapath.
package eth_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_SFD, S_ETH, S_IP, S_UDP, S_PAY, S_PAD, S_FCS, S_IFG
   } state_t;
   localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
   localparam logic [7:0]  SFD_BYTE       = 8'hD5;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam logic [10:0] MIN_PAYLOAD    = 11'd18;
   localparam logic [31:0] CRC_POLY       = 32'h04C11DB7;
   localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;
   function automatic logic [31:0] rev32(input logic [31:0] v);
      for (int i = 0; i < 32; i++) rev32[i] = v[31-i];
   endfunction
   localparam logic [31:0] CRC_POLY_REFL  = rev32(CRC_POLY);
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-wide reflected CRC-32 register with init/enable, shared with the receive path.
module eth_crc32_d8
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_init,
   input  logic        i_en,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);
   logic [31:0] crc_q, crc_d, nxt;
   always_comb begin
      nxt = crc_q;
      for (int i = 0; i < 8; i++) nxt = (nxt >> 1) ^ ((nxt[0] ^ i_data[i]) ? CRC_POLY_REFL : 32'h0);
      crc_d = i_init ? 32'hFFFFFFFF : i_en ? nxt : crc_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) crc_q <= 32'hFFFFFFFF;
      else        crc_q <= crc_d;
   assign o_crc = crc_q;
endmodule

// File: rtl/eth_udp_frame_tx.sv
// eth_udp_frame_tx: Ethernet/IPv4/UDP frame generator emitting one registered wire byte per clock.
module eth_udp_frame_tx
   import eth_pkg::*;
#(
   parameter logic [47:0] DST_MAC     = 48'hD8D38526C578,
   parameter logic [47:0] SRC_MAC     = 48'h0023543C471B,
   parameter logic [31:0] SRC_IP      = 32'hC0A84D21,
   parameter logic [31:0] DST_IP      = 32'hC0A84DD9,
   parameter logic [15:0] SRC_PORT    = 16'hC350,
   parameter logic [15:0] DST_PORT    = 16'hC360,
   parameter logic [7:0]  TTL         = 8'h40,
   parameter int          PAYLOAD_MAX = 1472,
   parameter int          IFG_BYTES   = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [10:0] i_len,
   input  logic [7:0]  i_pl_data,
   output logic        o_pl_rd,
   output logic [7:0]  o_data,
   output logic        o_valid,
   output logic        o_sof,
   output logic        o_eof,
   output logic        o_busy,
   output logic        o_done
);
   localparam logic [10:0] LEN_MAX = 11'(PAYLOAD_MAX);
   localparam logic [10:0] IFG_LEN = 11'(IFG_BYTES);
   state_t       state_q, state_d;
   logic [10:0]  cnt_q, cnt_d, len_q, len_d, lim;
   logic [15:0]  ident_q, ident_d, csum_q, csum_d, totlen, udplen;
   logic [19:0]  sum_q, sum_d;
   logic [16:0]  fold_q, fold_d;
   logic [335:0] hdr_q, hdr_d;
   logic [7:0]   data_q, data_d;
   logic         valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, busy_q, busy_d, done_q, done_d;
   logic         accept, last, hdr_out, crc_en;
   logic [31:0]  crc, fcs;

   // State/cnt describe the byte currently on o_data; *_d describe the byte being registered next.
   always_comb begin
      accept = state_q == S_IDLE && i_start;
      len_d = accept ? (i_len > LEN_MAX ? LEN_MAX : i_len) : len_q;
      lim = state_q == S_PRE ? 11'd7 : state_q == S_SFD ? 11'd1 : state_q == S_ETH ? 11'd14 :
            state_q == S_IP ? 11'd20 : state_q == S_UDP ? 11'd8 : state_q == S_PAY ? len_q :
            state_q == S_PAD ? MIN_PAYLOAD - len_q : state_q == S_FCS ? 11'd4 : IFG_LEN;
      last = cnt_q == lim - 11'd1;
      state_d = state_q;
      if (accept) state_d = S_PRE;
      else if (state_q != S_IDLE && last)
         unique case (state_q)
            S_PRE:   state_d = S_SFD;
            S_SFD:   state_d = S_ETH;
            S_ETH:   state_d = S_IP;
            S_IP:    state_d = S_UDP;
            S_UDP:   state_d = len_q == 11'd0 ? S_PAD : S_PAY;
            S_PAY:   state_d = len_q >= MIN_PAYLOAD ? S_FCS : S_PAD;
            S_PAD:   state_d = S_FCS;
            S_FCS:   state_d = IFG_BYTES == 0 ? S_IDLE : S_IFG;
            default: state_d = S_IDLE;
         endcase
      cnt_d = (state_d != state_q || state_q == S_IDLE) ? 11'd0 : cnt_q + 11'd1;
      totlen = 16'd28 + {5'b0, len_q};
      udplen = 16'd8 + {5'b0, len_q};
      sum_d = 20'h04500 + {4'b0, totlen} + {4'b0, ident_q} + 20'h04000 + {4'b0, TTL, IP_PROTO_UDP} +
              {4'b0, SRC_IP[31:16]} + {4'b0, SRC_IP[15:0]} + {4'b0, DST_IP[31:16]} + {4'b0, DST_IP[15:0]};
      fold_d = {1'b0, sum_q[15:0]} + {13'b0, sum_q[19:16]};
      csum_d = ~(fold_q[15:0] + {15'b0, fold_q[16]});
      hdr_out = state_d inside {S_ETH, S_IP, S_UDP};
      hdr_d = (state_q == S_PRE && state_d == S_SFD) ?
              {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, 16'h4500, totlen, ident_q, 16'h4000, TTL, IP_PROTO_UDP,
               csum_q, SRC_IP, DST_IP, SRC_PORT, DST_PORT, udplen, 16'h0000} :
              hdr_out ? {hdr_q[327:0], 8'h00} : hdr_q;
      fcs = ~crc;
      data_d = state_d == S_PRE ? PREAMBLE_BYTE : state_d == S_SFD ? SFD_BYTE :
               hdr_out ? hdr_q[335:328] : state_d == S_PAY ? i_pl_data :
               state_d == S_FCS ? fcs[{cnt_d[1:0], 3'b000} +: 8] : 8'h00;
      crc_en = state_d inside {S_ETH, S_IP, S_UDP, S_PAY, S_PAD};
      o_pl_rd = state_d == S_PAY;
      valid_d = state_d != S_IDLE && state_d != S_IFG;
      sof_d = accept;
      eof_d = state_d == S_FCS && cnt_d == 11'd3;
      busy_d = state_d != S_IDLE;
      done_d = busy_q && !busy_d;
      ident_d = ident_q + {15'b0, eof_q};
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         ident_q <= '0;
         sum_q   <= '0;
         fold_q  <= '0;
         csum_q  <= '0;
         hdr_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ident_q <= ident_d;
         sum_q   <= sum_d;
         fold_q  <= fold_d;
         csum_q  <= csum_d;
         hdr_q   <= hdr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end

   eth_crc32_d8 u_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_init (accept),
      .i_en   (crc_en),
      .i_data (data_d),
      .o_crc  (crc)
   );

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_sof   = sof_q;
   assign o_eof   = eof_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
endmodule

// File: tb/tb_eth_udp_frame_tx.sv
// tb_eth_udp_frame_tx: table-driven frame checks plus mid-frame reset and held-start sequences.
module tb_eth_udp_frame_tx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [10:0] i_len = '0;
   logic [7:0]  i_pl_data;
   logic        o_pl_rd, o_valid, o_sof, o_eof, o_busy, o_done;
   logic [7:0]  o_data;

   typedef struct {
      logic [10:0] len_in;
      int          len;
      logic [15:0] csum;
      logic [15:0] ident;
      int          n;
      int          pad;
      logic [31:0] seed;
      bit          hold;
   } vec_t;

   vec_t        tbl[9];
   int          n_chk = 0, n_fail = 0, cur = 0;
   int          rd_total = 0, rd_base = 0;
   logic [31:0] seed = '0;
   logic [7:0]  fb[0:1599];

   eth_udp_frame_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (i_start),
      .i_len     (i_len),
      .i_pl_data (i_pl_data),
      .o_pl_rd   (o_pl_rd),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_sof     (o_sof),
      .o_eof     (o_eof),
      .o_busy    (o_busy),
      .o_done    (o_done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pl_byte(input int k, input logic [31:0] s);
      if (k < 4) return s[31 - 8*k -: 8];
      return 8'(k * 5 + 3);
   endfunction

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
      c ^= {24'h0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // Show-ahead FIFO model: the head byte advances on each consumed read.
   always @(posedge clk) if (o_pl_rd) rd_total <= rd_total + 1;
   assign i_pl_data = pl_byte(rd_total - rd_base, seed);

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL f%0d %s: got %0h, expected %0h", cur, name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v);
      int c = 0, nv = 0, first_v = 0, last_v = 0, eof_at = 0, neof = 0, nsof = 0;
      int nrd = 0, nifg = 0, done_at = 0, busy_drop = 0, nbad;
      logic [335:0] h;
      logic [31:0]  crc, rev;
      seed = v.seed;
      rd_base = rd_total;
      i_len = v.len_in;
      i_start = 1'b1;
      while (done_at == 0 && c < 3000) begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            chk("sof_first", {o_sof, o_valid, o_busy, o_data}, {3'b111, 8'h55});
            if (!v.hold) i_start = 1'b0;
         end
         if (o_valid && nv < 1600) begin
            if (nv == 0) first_v = c;
            last_v = c;
            fb[nv] = o_data;
            nv++;
         end
         if (o_sof) nsof++;
         if (o_eof) begin neof++; eof_at = c; end
         if (o_pl_rd) nrd++;
         if (o_busy && !o_valid) nifg++;
         if (!o_busy && !o_done) busy_drop++;
         if (o_done) done_at = c;
      end
      chk("done_cycle", done_at, v.n + 13);
      chk("byte_count", nv, v.n);
      chk("no_bubbles", last_v - first_v + 1, v.n);
      chk("eof_pos", eof_at, v.n);
      chk("eof_sof_pulses", {neof, nsof}, {32'd1, 32'd1});
      chk("pl_rd_pulses", nrd, v.len);
      chk("ifg_cycles", nifg, 12);
      chk("busy_steady", busy_drop, 0);
      nbad = 0;
      for (int j = 0; j < 7; j++) if (fb[j] != 8'h55) nbad++;
      if (fb[7] != 8'hD5) nbad++;
      chk("preamble_sfd", nbad, 0);
      h = {48'hD8D38526C578, 48'h0023543C471B, 16'h0800, 16'h4500, 16'(28 + v.len), v.ident,
           16'h4000, 8'h40, 8'h11, v.csum, 32'hC0A84D21, 32'hC0A84DD9, 16'hC350, 16'hC360,
           16'(8 + v.len), 16'h0000};
      nbad = 0;
      for (int j = 0; j < 42; j++) if (fb[8 + j] != h[335 - 8*j -: 8]) nbad++;
      chk("header_bytes", nbad, 0);
      chk("ip_csum", {fb[32], fb[33]}, v.csum);
      chk("ip_ident", {fb[26], fb[27]}, v.ident);
      nbad = 0;
      for (int k = 0; k < v.len; k++) if (fb[50 + k] != pl_byte(k, v.seed)) nbad++;
      chk("payload", nbad, 0);
      chk("pad_len", nv - 54 - v.len, v.pad);
      nbad = 0;
      for (int k = 50 + v.len; k < nv - 4; k++) if (fb[k] != 8'h00) nbad++;
      chk("pad_zero", nbad, 0);
      crc = 32'hFFFFFFFF;
      for (int k = 8; k < nv; k++) crc = crc_step(crc, fb[k]);
      for (int j = 0; j < 32; j++) rev[j] = crc[31 - j];
      chk("crc_residue", rev, 32'hC704DD7B);
   endtask

   task automatic mid_reset();
      int w = 0;
      seed = 32'h11223344;
      rd_base = rd_total;
      i_len = 11'd100;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      while (rd_total - rd_base < 5 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("abort_in_payload", {o_valid, o_busy, 1'b0, w < 200}, 4'b1101);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", {o_data, o_valid, o_sof, o_eof, o_busy, o_done, o_pl_rd}, 14'h0);
      @(negedge clk);
      @(negedge clk);
      chk("abort_held", {o_data, o_valid, o_busy, o_pl_rd}, 11'h0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{11'd4,    4,    16'h1E82, 16'd0, 72,   14, 32'hDEADBEEF, 1'b0};
      tbl[1] = '{11'd4,    4,    16'h1E81, 16'd1, 72,   14, 32'h01020304, 1'b0};
      tbl[2] = '{11'd0,    0,    16'h1E84, 16'd2, 72,   18, 32'h0,        1'b0};
      tbl[3] = '{11'd2000, 1472, 16'h18C3, 16'd3, 1526, 0,  32'hA5A55A5A, 1'b0};
      tbl[4] = '{11'd18,   18,   16'h1E70, 16'd4, 72,   0,  32'hCAFEF00D, 1'b0};
      tbl[5] = '{11'd17,   17,   16'h1E70, 16'd5, 72,   1,  32'h12345678, 1'b0};
      tbl[6] = '{11'd4,    4,    16'h1E82, 16'd0, 72,   14, 32'hDEADBEEF, 1'b0};
      tbl[7] = '{11'd5,    5,    16'h1E80, 16'd1, 72,   13, 32'h0BADC0DE, 1'b1};
      tbl[8] = '{11'd5,    5,    16'h1E7F, 16'd2, 72,   13, 32'hFEEDFACE, 1'b1};
      repeat (3) @(negedge clk);
      chk("reset_outputs", {o_data, o_valid, o_sof, o_eof, o_busy, o_done, o_pl_rd}, 14'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {o_valid, o_busy, o_pl_rd}, 3'b000);
      for (int i = 0; i < 9; i++) begin
         cur = i;
         if (i == 6) mid_reset();
         run_frame(tbl[i]);
      end
      i_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_hold", {o_valid, o_busy, o_sof}, 3'b000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
